// File: rtl/vx_dispatch_batch_ctrl_pkg.sv
// Shared types and sizing helpers for the dispatch batch controller.
// Default geometry is four issue slots served two at a time.
package vx_dispatch_batch_ctrl_pkg;

    localparam int ISSUE_WIDTH_DEF = 4;
    localparam int BLOCK_SIZE_DEF  = 2;

    typedef enum logic {
        BCTL_IDLE,
        BCTL_ACTIVE
    } bctl_state_t;

    // Index width that never collapses to zero bits for a single batch.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_batch_ctrl_if.sv
// Issue-slot / execute-block handshake bundle for the batch controller.
// The master side drives the slot and eop lines; the controller is the slave.
interface vx_dispatch_batch_ctrl_if
    import vx_dispatch_batch_ctrl_pkg::*;
#(
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF
);
    localparam int BATCH_COUNT_W = log2up(ISSUE_WIDTH / BLOCK_SIZE);

    logic [ISSUE_WIDTH-1:0]   slot_valid;
    logic [BLOCK_SIZE-1:0]    blk_eop_fire;
    logic [BATCH_COUNT_W-1:0] batch_idx;
    logic                     batch_active;
    logic [BLOCK_SIZE-1:0]    blk_enable;
    logic                     batch_done;

    modport master (
        output slot_valid, blk_eop_fire,
        input  batch_idx, batch_active, blk_enable, batch_done
    );

    modport slave (
        input  slot_valid, blk_eop_fire,
        output batch_idx, batch_active, blk_enable, batch_done
    );

endinterface

// File: rtl/vx_dispatch_batch_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after start,
// wrapping explicitly at NUM so non-power-of-two counts are handled.
module vx_dispatch_batch_ctrl_rr_arbiter #(
    parameter int NUM = 2,
    parameter int W   = 1
) (
    input  logic [NUM-1:0] requests,
    input  logic [W-1:0]   start,
    output logic           grant_valid,
    output logic [W-1:0]   grant_index
);
    int          cand;
    logic [W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        cand        = 0;
        idx         = '0;
        for (int i = 0; i < NUM; i++) begin
            cand = int'(start) + i;
            if (cand >= NUM) cand = cand - NUM;
            idx = W'(cand);
            if (!grant_valid && requests[idx]) begin
                grant_valid = 1'b1;
                grant_index = idx;
            end
        end
    end

endmodule

// File: rtl/vx_dispatch_batch_ctrl.sv
// Dispatch batch scheduler: grants the execute blocks to one batch of issue
// slots at a time, round-robin, holding each grant until every block signals eop.
module vx_dispatch_batch_ctrl
    import vx_dispatch_batch_ctrl_pkg::*;
#(
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF
) (
    input logic                     clk,
    input logic                     reset,
    vx_dispatch_batch_ctrl_if.slave bus
);
    localparam int BATCH_COUNT   = ISSUE_WIDTH / BLOCK_SIZE;
    localparam int BATCH_COUNT_W = log2up(BATCH_COUNT);
    localparam logic [BATCH_COUNT_W-1:0] LAST_BATCH = BATCH_COUNT_W'(BATCH_COUNT - 1);

    bctl_state_t              state;
    logic                     batch_active;
    logic [BATCH_COUNT_W-1:0] batch_idx;
    logic [BATCH_COUNT_W-1:0] rr_ptr;
    logic [BATCH_COUNT_W-1:0] next_idx;
    logic [BATCH_COUNT_W-1:0] arb_start;
    logic [BATCH_COUNT_W-1:0] arb_index;
    logic                     arb_valid;
    logic [BATCH_COUNT-1:0]   bvalid;
    logic [BATCH_COUNT-1:0]   arb_req;
    logic [BLOCK_SIZE-1:0]    bslots [BATCH_COUNT];
    logic [BLOCK_SIZE-1:0]    done_mask;
    logic [BLOCK_SIZE-1:0]    done_nxt;
    logic [BLOCK_SIZE-1:0]    grant_slots;
    logic                     complete;

    for (genvar k = 0; k < BATCH_COUNT; k++) begin : g_batch
        assign bslots[k] = bus.slot_valid[k*BLOCK_SIZE +: BLOCK_SIZE];
        assign bvalid[k] = |bslots[k];
    end

    assign next_idx    = (batch_idx == LAST_BATCH) ? '0 : batch_idx + 1'b1;
    assign done_nxt    = done_mask | bus.blk_eop_fire;
    assign complete    = (state == BCTL_ACTIVE) && (&done_nxt);
    assign grant_slots = bslots[arb_index];

    always_comb begin
        arb_start = (state == BCTL_ACTIVE) ? next_idx : rr_ptr;
        arb_req   = bvalid;
        // A finishing batch yields to the others; with a single batch it re-grants itself.
        if (state == BCTL_ACTIVE && BATCH_COUNT > 1) arb_req[batch_idx] = 1'b0;
    end

    vx_dispatch_batch_ctrl_rr_arbiter #(
        .NUM (BATCH_COUNT),
        .W   (BATCH_COUNT_W)
    ) u_arb (
        .requests    (arb_req),
        .start       (arb_start),
        .grant_valid (arb_valid),
        .grant_index (arb_index)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BCTL_IDLE;
            batch_active <= 1'b0;
            batch_idx    <= '0;
            rr_ptr       <= '0;
            done_mask    <= '0;
        end else begin
            case (state)
                BCTL_IDLE: begin
                    if (arb_valid) begin
                        state        <= BCTL_ACTIVE;
                        batch_active <= 1'b1;
                        batch_idx    <= arb_index;
                        done_mask    <= ~grant_slots;
                    end
                end
                BCTL_ACTIVE: begin
                    if (&done_nxt) begin
                        rr_ptr <= next_idx;
                        if (arb_valid) begin
                            batch_idx <= arb_index;
                            done_mask <= ~grant_slots;
                        end else begin
                            state        <= BCTL_IDLE;
                            batch_active <= 1'b0;
                            done_mask    <= '0;
                        end
                    end else begin
                        done_mask <= done_nxt;
                    end
                end
                default: state <= BCTL_IDLE;
            endcase
        end
    end

    assign bus.batch_idx    = batch_idx;
    assign bus.batch_active = batch_active;
    assign bus.blk_enable   = batch_active ? ~done_mask : '0;
    assign bus.batch_done   = complete;

endmodule

// File: tb/tb_vx_dispatch_batch_ctrl.sv
// Directed bench for the batch controller: a 2-batch instance (4 slots, 2 per
// batch) driven from a vector table plus hand sequences, and a 1-batch instance.
module tb_vx_dispatch_batch_ctrl;

    logic clk;
    logic reset;

    vx_dispatch_batch_ctrl_if #(.ISSUE_WIDTH(4), .BLOCK_SIZE(2)) bus0 ();
    vx_dispatch_batch_ctrl_if #(.ISSUE_WIDTH(2), .BLOCK_SIZE(2)) bus1 ();

    vx_dispatch_batch_ctrl #(.ISSUE_WIDTH(4), .BLOCK_SIZE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    vx_dispatch_batch_ctrl #(.ISSUE_WIDTH(2), .BLOCK_SIZE(2)) dut_bc1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sv;
        logic [1:0] eop;
        logic       act;
        logic       idx;
        logic [1:0] en;
        logic       done;
    } row_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic row_t mk(input logic rst, input logic [3:0] sv, input logic [1:0] eop,
                                input logic act, input logic idx, input logic [1:0] en,
                                input logic done);
        row_t r;
        r.rst = rst; r.sv = sv; r.eop = eop;
        r.act = act; r.idx = idx; r.en = en; r.done = done;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the edge, compare outputs mid-cycle.
    task automatic apply(input string tag, input bit bc1, input row_t r);
        @(posedge clk);
        #1;
        reset = r.rst;
        if (bc1) begin
            bus0.slot_valid = '0;      bus0.blk_eop_fire = '0;
            bus1.slot_valid = r.sv[1:0]; bus1.blk_eop_fire = r.eop;
        end else begin
            bus0.slot_valid = r.sv;    bus0.blk_eop_fire = r.eop;
            bus1.slot_valid = '0;      bus1.blk_eop_fire = '0;
        end
        @(negedge clk);
        if (bc1) begin
            check({tag, ".active"}, 32'(bus1.batch_active), 32'(r.act));
            check({tag, ".idx"},    32'(bus1.batch_idx),    32'(r.idx));
            check({tag, ".enable"}, 32'(bus1.blk_enable),   32'(r.en));
            check({tag, ".done"},   32'(bus1.batch_done),   32'(r.done));
        end else begin
            check({tag, ".active"}, 32'(bus0.batch_active), 32'(r.act));
            check({tag, ".idx"},    32'(bus0.batch_idx),    32'(r.idx));
            check({tag, ".enable"}, 32'(bus0.blk_enable),   32'(r.en));
            check({tag, ".done"},   32'(bus0.batch_done),   32'(r.done));
        end
    endtask

    row_t vec[$];

    initial begin
        reset = 1'b1;
        bus0.slot_valid = '0; bus0.blk_eop_fire = '0;
        bus1.slot_valid = '0; bus1.blk_eop_fire = '0;
        repeat (2) @(posedge clk);

        //          rst  sv       eop    act idx en     done
        // Reset release, two-block batch, eops on different cycles, then idle.
        vec.push_back(mk(1, 4'b0011, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b0011, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b0011, 2'b00, 1, 0, 2'b11, 0));
        vec.push_back(mk(0, 4'b0011, 2'b01, 1, 0, 2'b11, 0));
        vec.push_back(mk(0, 4'b0010, 2'b00, 1, 0, 2'b10, 0));
        vec.push_back(mk(0, 4'b0010, 2'b10, 1, 0, 2'b10, 1));
        vec.push_back(mk(0, 4'b0000, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b0000, 2'b11, 0, 0, 2'b00, 0));
        // Partial batch: slot 1 invalid at grant is pre-done; its eop is ignored.
        vec.push_back(mk(0, 4'b0001, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b0001, 2'b00, 1, 0, 2'b01, 0));
        vec.push_back(mk(0, 4'b0001, 2'b10, 1, 0, 2'b01, 0));
        vec.push_back(mk(0, 4'b0000, 2'b01, 1, 0, 2'b01, 1));
        vec.push_back(mk(0, 4'b0000, 2'b00, 0, 0, 2'b00, 0));
        // Fresh pointer, all slots valid: back-to-back grants 0,1,0,1.
        vec.push_back(mk(1, 4'b0000, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b1111, 2'b00, 0, 0, 2'b00, 0));
        vec.push_back(mk(0, 4'b1111, 2'b00, 1, 0, 2'b11, 0));
        vec.push_back(mk(0, 4'b1111, 2'b11, 1, 0, 2'b11, 1));
        vec.push_back(mk(0, 4'b1111, 2'b11, 1, 1, 2'b11, 1));
        vec.push_back(mk(0, 4'b1111, 2'b11, 1, 0, 2'b11, 1));
        vec.push_back(mk(0, 4'b1111, 2'b01, 1, 1, 2'b11, 0));
        vec.push_back(mk(0, 4'b0000, 2'b00, 1, 1, 2'b10, 0));
        vec.push_back(mk(0, 4'b0000, 2'b10, 1, 1, 2'b10, 1));
        vec.push_back(mk(0, 4'b0000, 2'b00, 0, 1, 2'b00, 0));

        foreach (vec[i]) apply($sformatf("vec[%0d]", i), 1'b0, vec[i]);

        // Late-arriving slot 0 is not served by batch 1; batch 0 follows with no bubble.
        apply("late.idle",   1'b0, mk(0, 4'b1100, 2'b00, 0, 1, 2'b00, 0));
        apply("late.grant",  1'b0, mk(0, 4'b1101, 2'b00, 1, 1, 2'b11, 0));
        apply("late.eop0",   1'b0, mk(0, 4'b1101, 2'b01, 1, 1, 2'b11, 0));
        apply("late.done1",  1'b0, mk(0, 4'b0001, 2'b10, 1, 1, 2'b10, 1));
        apply("late.b0",     1'b0, mk(0, 4'b0001, 2'b00, 1, 0, 2'b01, 0));
        apply("late.done0",  1'b0, mk(0, 4'b0000, 2'b01, 1, 0, 2'b01, 1));
        apply("late.end",    1'b0, mk(0, 4'b0000, 2'b00, 0, 0, 2'b00, 0));

        // Reset mid-batch, then the pointer restarts at 0 and skips invalid batch 0.
        apply("rst.idle",    1'b0, mk(0, 4'b0011, 2'b00, 0, 0, 2'b00, 0));
        apply("rst.grant",   1'b0, mk(0, 4'b0011, 2'b01, 1, 0, 2'b11, 0));
        apply("rst.assert",  1'b0, mk(1, 4'b0011, 2'b00, 1, 0, 2'b10, 0));
        apply("rst.cleared", 1'b0, mk(0, 4'b1100, 2'b00, 0, 0, 2'b00, 0));
        apply("rst.regrant", 1'b0, mk(0, 4'b1100, 2'b00, 1, 1, 2'b11, 0));
        apply("rst.drain",   1'b0, mk(0, 4'b0000, 2'b11, 1, 1, 2'b11, 1));
        apply("rst.end",     1'b0, mk(0, 4'b0000, 2'b00, 0, 1, 2'b00, 0));

        // Single-batch instance: completion with slots still valid re-grants at once.
        apply("bc1.idle",    1'b1, mk(0, 4'b0011, 2'b00, 0, 0, 2'b00, 0));
        apply("bc1.eop0",    1'b1, mk(0, 4'b0011, 2'b01, 1, 0, 2'b11, 0));
        apply("bc1.done",    1'b1, mk(0, 4'b0011, 2'b10, 1, 0, 2'b10, 1));
        apply("bc1.reload",  1'b1, mk(0, 4'b0011, 2'b00, 1, 0, 2'b11, 0));
        apply("bc1.done2",   1'b1, mk(0, 4'b0001, 2'b11, 1, 0, 2'b11, 1));
        apply("bc1.partial", 1'b1, mk(0, 4'b0000, 2'b00, 1, 0, 2'b01, 0));
        apply("bc1.done3",   1'b1, mk(0, 4'b0000, 2'b01, 1, 0, 2'b01, 1));
        apply("bc1.end",     1'b1, mk(0, 4'b0000, 2'b00, 0, 0, 2'b00, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
